// File: rtl/pwm_write_sequencer_if.sv
// Command and register-bus signals of the PWM write sequencer.
// The host drives through the master modport and the sequencer through the slave modport.
interface pwm_write_sequencer_if;
    logic        CmdValid;
    logic        CmdReady;
    logic [5:0]  CmdChannel;
    logic [15:0] CmdDuty;
    logic [15:0] CmdPeriod;
    logic [15:0] CmdPrescale;
    logic [7:0]  AddressBus;
    logic [7:0]  DataOut;
    logic        _Write;
    logic        _HOLD;
    logic        Busy;
    logic        Error;

    modport master (
        output CmdValid, CmdChannel, CmdDuty, CmdPeriod, CmdPrescale,
        input  CmdReady, AddressBus, DataOut, _Write, _HOLD, Busy, Error
    );

    modport slave (
        input  CmdValid, CmdChannel, CmdDuty, CmdPeriod, CmdPrescale,
        output CmdReady, AddressBus, DataOut, _Write, _HOLD, Busy, Error
    );
endinterface

// File: rtl/pwm_write_sequencer.sv
// Writes duty/period/prescale of one PWM channel as six strobed bytes on a shared 8-bit register bus.
// Optional macro PWM_SEQ_HOLD_EN drives _HOLD low for the duration of each valid write sequence.
module pwm_write_sequencer #(
    parameter int NUM_CHANNELS  = 8,
    parameter int BASE_ADDRESS  = 0,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                  CLK,
    input  logic                  _RST,
    pwm_write_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        RECOVER = 3'd3,
        ERR     = 3'd4
    } state_t;

    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [6:0] NUM_CH      = 7'(NUM_CHANNELS);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [2:0]  offset_reg, offset_next;
    logic [5:0]  chan_reg;
    logic [15:0] duty_reg, period_reg, prescale_reg;
    logic [7:0]  addr_reg, addr_next;
    logic [7:0]  data_reg, data_next;
    logic        write_n_reg, busy_reg, error_reg, ready_reg;

    logic        load;
    logic        step;
    logic        ch_bad;
    logic [5:0]  addr_chan;
    logic [2:0]  addr_off;
    logic [8:0]  addr_sum;
    logic [15:0] words [0:2];
    logic [7:0]  byte_lane [0:7];

    assign ch_bad   = ({1'b0, bus.CmdChannel} >= NUM_CH);
    assign addr_sum = 9'(BASE_ADDRESS) + 9'(addr_chan) * 9'd6 + 9'(addr_off);

    assign words[0] = duty_reg;
    assign words[1] = period_reg;
    assign words[2] = prescale_reg;

    // Byte order on the bus: high byte of each field first; lanes 6 and 7 are never addressed.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            if (gi < 6) begin : g_used
                if (gi % 2 == 0) begin : g_hi
                    assign byte_lane[gi] = words[gi / 2][15:8];
                end else begin : g_lo
                    assign byte_lane[gi] = words[gi / 2][7:0];
                end
            end else begin : g_pad
                assign byte_lane[gi] = 8'h00;
            end
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        offset_next = offset_reg;
        load        = 1'b0;
        step        = 1'b0;
        addr_chan   = chan_reg;
        addr_off    = offset_reg + 3'd1;
        addr_next   = addr_reg;
        data_next   = data_reg;

        case (state_reg)
            IDLE: begin
                if (bus.CmdValid && ready_reg) begin
                    load      = 1'b1;
                    addr_chan = bus.CmdChannel;
                    addr_off  = 3'd0;
                    if (ch_bad) begin
                        state_next = ERR;
                    end else begin
                        state_next  = SETUP;
                        cnt_next    = 4'd0;
                        offset_next = 3'd0;
                    end
                end
            end
            SETUP: begin
                if (cnt_reg == SETUP_LAST) begin
                    state_next = STROBE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            STROBE: begin
                if (cnt_reg == STROBE_LAST) begin
                    state_next = RECOVER;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            RECOVER: begin
                if (offset_reg == 3'd5) begin
                    state_next = IDLE;
                end else begin
                    state_next  = SETUP;
                    cnt_next    = 4'd0;
                    offset_next = offset_reg + 3'd1;
                    step        = 1'b1;
                end
            end
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Address and data change only when a new byte begins, so they are stable through SETUP..RECOVER.
        if ((load && !ch_bad) || step) begin
            addr_next = addr_sum[7:0];
            data_next = load ? bus.CmdDuty[15:8] : byte_lane[offset_next];
        end
    end

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            offset_reg   <= 3'd0;
            chan_reg     <= 6'd0;
            duty_reg     <= 16'd0;
            period_reg   <= 16'd0;
            prescale_reg <= 16'd0;
            addr_reg     <= 8'd0;
            data_reg     <= 8'd0;
            write_n_reg  <= 1'b1;
            busy_reg     <= 1'b0;
            error_reg    <= 1'b0;
            ready_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            offset_reg <= offset_next;
            addr_reg   <= addr_next;
            data_reg   <= data_next;
            if (load) begin
                chan_reg     <= bus.CmdChannel;
                duty_reg     <= bus.CmdDuty;
                period_reg   <= bus.CmdPeriod;
                prescale_reg <= bus.CmdPrescale;
            end
            // Strobe and status outputs are registered from the next state to keep them glitch-free.
            write_n_reg <= (state_next != STROBE);
            busy_reg    <= (state_next != IDLE);
            error_reg   <= (state_next == ERR);
            ready_reg   <= (state_next == IDLE);
        end
    end

`ifdef PWM_SEQ_HOLD_EN
    logic hold_n_reg;

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            hold_n_reg <= 1'b1;
        end else begin
            hold_n_reg <= !((state_next == SETUP) || (state_next == STROBE) ||
                            (state_next == RECOVER));
        end
    end

    assign bus._HOLD = hold_n_reg;
`else
    assign bus._HOLD = 1'b1;
`endif

    assign bus.CmdReady   = ready_reg;
    assign bus.AddressBus = addr_reg;
    assign bus.DataOut    = data_reg;
    assign bus._Write     = write_n_reg;
    assign bus.Busy       = busy_reg;
    assign bus.Error      = error_reg;

endmodule
